// File: rtl/ds_pkg.sv
// ds_pkg: shared constants and types for the delta-sigma receive path.
// Values here describe the default build (DEC=64, ORDER=3, OUT_W=10).
package ds_pkg;

  localparam int DS_DEC      = 64;
  localparam int DS_ORDER    = 3;
  localparam int DS_OUT_W    = 10;
  localparam int DS_LOG2_DEC = $clog2(DS_DEC);

  // Accumulator width: one sign bit, one bit for the +/-1 input, ORDER*log2(DEC) growth.
  localparam int DS_W       = 2 + DS_ORDER * DS_LOG2_DEC;
  // Right shift that maps full scale DEC^ORDER onto 2^(OUT_W-1).
  localparam int DS_SHR     = DS_ORDER * DS_LOG2_DEC - (DS_OUT_W - 1);
  localparam int DS_SAT_MAX = (2 ** (DS_OUT_W - 1)) - 1;
  localparam int DS_SAT_MIN = -(2 ** (DS_OUT_W - 1));

  typedef logic signed [DS_W-1:0] cic_acc_t;

  // Accumulator width for an arbitrary decimation ratio and order.
  function automatic int cic_acc_w(input int dec, input int order);
    return 2 + order * $clog2(dec);
  endfunction

endpackage

// File: rtl/ds_sync2.sv
// ds_sync2: two-flop synchroniser with asynchronous active-high clear.
// Used on every pmod input that arrives asynchronously to clk.
module ds_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; only q is allowed to fan out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ds_cic_decim.sv
// ds_cic_decim: receive side of the 1-bit delta-sigma ADC.
// Synchronises the comparator bit, re-drives it as DAC feedback and
// decimates it with a 3rd-order CIC to signed OUT_W-bit samples at f_cke/DEC.
// Build option: define DS_OVF_FLAG_EN to add the ovf saturation flag port.
//
// Output protocol: dout_valid is a single-cycle strobe with no back-pressure;
// dout is stable from that cycle until the next strobe, and ovf (when present)
// is only meaningful while dout_valid is high.
module ds_cic_decim
  import ds_pkg::*;
#(
  parameter int DEC   = DS_DEC,
  parameter int ORDER = DS_ORDER,
  parameter int OUT_W = DS_OUT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cke,
  input  logic                    bit_in,
  output logic                    fb_out,
  output logic signed [OUT_W-1:0] dout,
  output logic                    dout_valid
`ifdef DS_OVF_FLAG_EN
  ,
  output logic                    ovf
`endif
);

  localparam int LOG2_DEC = $clog2(DEC);
  localparam int ACC_W    = cic_acc_w(DEC, ORDER);
  localparam int SHR_L    = ORDER * LOG2_DEC - (OUT_W - 1);
  localparam int SC_W     = ACC_W + OUT_W;

  localparam logic [LOG2_DEC-1:0]     CNT_LAST = LOG2_DEC'(DEC - 1);
  localparam logic signed [OUT_W-1:0] OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [SC_W-1:0]  SC_MAX   = SC_W'(OUT_MAX);
  localparam logic signed [SC_W-1:0]  SC_MIN   = SC_W'(OUT_MIN);

  typedef logic signed [ACC_W-1:0] acc_t;

  // The comb section below is written for exactly three stages.
  if (ORDER != 3) begin : g_bad_order
    $error("ds_cic_decim: ORDER must be 3");
  end
  if (DEC < 4 || DEC > 256 || (DEC & (DEC - 1)) != 0) begin : g_bad_dec
    $error("ds_cic_decim: DEC must be a power of two in 4..256");
  end
  if (DEC == DS_DEC && OUT_W == DS_OUT_W &&
      (ACC_W != DS_W || SHR_L != DS_SHR ||
       int'(OUT_MAX) != DS_SAT_MAX || int'(OUT_MIN) != DS_SAT_MIN)) begin : g_bad_pkg
    $error("ds_cic_decim: package constants disagree with module sizing");
  end

  logic                bit_s;
  acc_t                x;
  logic [LOG2_DEC-1:0] cnt;
  logic                dec_stb;
  acc_t                integ [ORDER];
  acc_t                dly   [ORDER];
  acc_t                c0, c1, c2, c3;
  logic signed [SC_W-1:0]  c3_ext, scaled;
  logic                sat_hi, sat_lo;
  logic signed [OUT_W-1:0] sat_val;

  ds_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bit_in),
    .q   (bit_s)
  );

  // Bipolar mapping of the synchronised bit.
  assign x = bit_s ? acc_t'(1) : '1;

  // Feedback to the external DAC: exactly the sample the integrators take.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      fb_out <= 1'b0;
    else if (cke) fb_out <= bit_s;
  end

  // Integrator chain; every stage adds its predecessor's pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < ORDER; k++) integ[k] <= '0;
    end else if (cke) begin
      integ[0] <= integ[0] + x;
      for (int k = 1; k < ORDER; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  // Decimation phase counter; DEC is a power of two so it wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (cke) cnt <= cnt + LOG2_DEC'(1);
  end

  assign dec_stb = cke && (cnt == CNT_LAST);

  // Comb differences, modulo 2^ACC_W; wrap in the integrators cancels here.
  assign c0 = integ[ORDER-1];
  assign c1 = c0 - dly[0];
  assign c2 = c1 - dly[1];
  assign c3 = c2 - dly[2];

  // Comb delay registers advance once per output sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < ORDER; k++) dly[k] <= '0;
    end else if (dec_stb) begin
      dly[0] <= c0;
      dly[1] <= c1;
      dly[2] <= c2;
    end
  end

  // Scale full scale to 2^(OUT_W-1); small DEC needs a left shift instead.
  assign c3_ext = SC_W'(c3);
  if (SHR_L >= 0) begin : g_shr
    assign scaled = c3_ext >>> SHR_L;
  end else begin : g_shl
    assign scaled = c3_ext <<< (-SHR_L);
  end

  assign sat_hi  = scaled > SC_MAX;
  assign sat_lo  = scaled < SC_MIN;
  assign sat_val = sat_hi ? OUT_MAX : (sat_lo ? OUT_MIN : scaled[OUT_W-1:0]);

  // Output register and its one-cycle strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= dec_stb;
      if (dec_stb) dout <= sat_val;
    end
  end

`ifdef DS_OVF_FLAG_EN
  // Saturation flag, aligned with dout_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf <= 1'b0;
    else     ovf <= dec_stb && (sat_hi || sat_lo);
  end
`endif

endmodule
